bus_mux_reg: RTL and testbench

Parametrised, registered successor to the CPU's 32:1 bus multiplexer. Selects one of `N_SRC` data sources onto the shared datapath bus from one-hot `out` enables (R0out…Cout). The bus value is registered and held between transfers. One-hot violations are detected, counted and reported. Sits between the register file, special registers (HI, LO, Z, PC, MDR, InPort) and all bus consumers.

---
 rtl/bus_mux_if.sv | 28 ++
 rtl/bus_mux_reg.sv | 86 ++++++++
 tb/tb_bus_mux_reg.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_mux_if.sv
// Bus bundle for bus_mux_reg: one-hot source enables and flattened source
// data in, the registered bus value and its status out.
interface bus_mux_if #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 24,
  parameter int SEL_W = 5,
  parameter int CNT_W = 8
);
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_en;
  logic                   hold;
  logic                   conflict_clr;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [SEL_W-1:0]       sel_q;
  logic                   conflict;
  logic [CNT_W-1:0]       conflict_cnt;

  modport master (
    output src_data, src_en, hold, conflict_clr,
    input  bus_out, bus_valid, sel_q, conflict, conflict_cnt
  );

  modport slave (
    input  src_data, src_en, hold, conflict_clr,
    output bus_out, bus_valid, sel_q, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered N_SRC:1 datapath bus multiplexer. The lowest enabled source
// wins, the bus value is held between transfers, and cycles with more than
// one enable are flagged (sticky) and counted (saturating).
module bus_mux_reg #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 24,
  parameter int SEL_W = 5,
  parameter int CNT_W = 8
) (
  input logic     clk,
  input logic     clear,
  bus_mux_if.slave bus
);

  logic [SEL_W-1:0] winner_s;
  logic [WIDTH-1:0] data_s;
  logic             any_s;
  logic             multi_s;

  logic [WIDTH-1:0] bus_out_r;
  logic [SEL_W-1:0] sel_r;
  logic             bus_valid_r;
  logic             conflict_r;
  logic [CNT_W-1:0] conflict_cnt_r;

  // Priority-encode the enables (source 0 highest) and pick the winning data word.
  always_comb begin
    winner_s = {SEL_W{1'b0}};
    data_s   = {WIDTH{1'b0}};
    any_s    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!any_s && bus.src_en[i]) begin
        winner_s = SEL_W'(i);
        data_s   = bus.src_data[i*WIDTH +: WIDTH];
        any_s    = 1'b1;
      end else begin
        any_s    = any_s;
      end
    end
  end

  // Two or more enables: clearing the lowest set bit still leaves something.
  assign multi_s = (bus.src_en & (bus.src_en - N_SRC'(1))) != {N_SRC{1'b0}};

  // Bus register, valid flag and conflict bookkeeping; hold freezes everything.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      bus_out_r      <= {WIDTH{1'b0}};
      sel_r          <= {SEL_W{1'b0}};
      bus_valid_r    <= 1'b0;
      conflict_r     <= 1'b0;
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.hold) begin
      bus_valid_r    <= 1'b0;
    end else begin
      if (any_s) begin
        bus_out_r    <= data_s;
        sel_r        <= winner_s;
        bus_valid_r  <= 1'b1;
      end else begin
        bus_valid_r  <= 1'b0;
      end
      // Clear wins over a conflict arriving in the same cycle.
      if (bus.conflict_clr) begin
        conflict_r     <= 1'b0;
        conflict_cnt_r <= {CNT_W{1'b0}};
      end else if (multi_s) begin
        conflict_r     <= 1'b1;
        if (conflict_cnt_r != {CNT_W{1'b1}}) begin
          conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
        end else begin
          conflict_cnt_r <= conflict_cnt_r;
        end
      end else begin
        conflict_r     <= conflict_r;
      end
    end
  end

  assign bus.bus_out      = bus_out_r;
  assign bus.sel_q        = sel_r;
  assign bus.bus_valid    = bus_valid_r;
  assign bus.conflict     = conflict_r;
  assign bus.conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Self-checking bench for bus_mux_reg: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a
// behavioural model.
module tb_bus_mux_reg;
  localparam int WIDTH = 32;
  localparam int N     = 24;
  localparam int SEL_W = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = 255;

  logic clk = 1'b0;
  logic clear;
  bit   chk_on = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bus_mux_if #(.WIDTH(WIDTH), .N_SRC(N), .SEL_W(SEL_W), .CNT_W(CNT_W)) bif ();

  bus_mux_reg #(.WIDTH(WIDTH), .N_SRC(N), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bif)
  );

  // Behavioural model state
  logic [WIDTH-1:0] m_bus;
  int               m_sel;
  bit               m_valid;
  bit               m_conf;
  int               m_cnt;

  function automatic int lowest(input logic [N-1:0] e);
    for (int i = 0; i < N; i++) if (e[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply the transfer rules at each edge, reset asynchronously.
  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_bus <= '0; m_sel <= 0; m_valid <= 1'b0; m_conf <= 1'b0; m_cnt <= 0;
    end else if (bif.hold) begin
      m_valid <= 1'b0;
    end else begin
      if (bif.src_en != '0) begin
        m_bus   <= bif.src_data[lowest(bif.src_en)*WIDTH +: WIDTH];
        m_sel   <= lowest(bif.src_en);
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
      if (bif.conflict_clr) begin
        m_conf <= 1'b0; m_cnt <= 0;
      end else if ($countones(bif.src_en) >= 2) begin
        m_conf <= 1'b1;
        m_cnt  <= (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
    end
  end

  // Compare DUT outputs with the model mid-cycle.
  always @(negedge clk) begin
    if (chk_on && !clear) begin
      chk("m_bus_out",   64'(bif.bus_out),      64'(m_bus));
      chk("m_sel_q",     64'(bif.sel_q),        64'(m_sel));
      chk("m_bus_valid", 64'(bif.bus_valid),    64'(m_valid));
      chk("m_conflict",  64'(bif.conflict),     64'(m_conf));
      chk("m_cnt",       64'(bif.conflict_cnt), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bus"},   64'(bif.bus_out),      64'h0);
    chk({tag, "_sel"},   64'(bif.sel_q),        64'h0);
    chk({tag, "_valid"}, 64'(bif.bus_valid),    64'h0);
    chk({tag, "_conf"},  64'(bif.conflict),     64'h0);
    chk({tag, "_cnt"},   64'(bif.conflict_cnt), 64'h0);
  endtask

  logic [WIDTH-1:0] d_saved;
  logic [SEL_W-1:0] s_saved;
  logic [CNT_W-1:0] c_saved;

  initial begin
    clear = 1'b1;
    bif.src_data = '0; bif.src_en = '0; bif.hold = 1'b0; bif.conflict_clr = 1'b0;
    bif.src_en = N'(1);
    bif.src_data[0 +: WIDTH] = 32'hDEAD_BEEF;
    repeat (2) step();
    chk_zero("reset");
    clear = 1'b0;
    chk_on = 1'b1;
    step();
    chk("rst_rel_bus",   64'(bif.bus_out),   64'hDEAD_BEEF);
    chk("rst_rel_sel",   64'(bif.sel_q),     64'h0);
    chk("rst_rel_valid", 64'(bif.bus_valid), 64'h1);
    // Asynchronous clear mid-cycle
    #3 clear = 1'b1;
    #1 chk_zero("async_clr");
    @(negedge clk); #1 clear = 1'b0;
    step();
    chk("post_clr_bus", 64'(bif.bus_out), 64'hDEAD_BEEF);

    // Sweep every source back to back
    for (int i = 0; i < N; i++) begin
      bif.src_data[i*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(i);
      bif.src_en = N'(1) << i;
      step();
      chk("sweep_bus",   64'(bif.bus_out),   64'(32'h1000_0000 + 32'(i)));
      chk("sweep_sel",   64'(bif.sel_q),     64'(i));
      chk("sweep_valid", 64'(bif.bus_valid), 64'h1);
    end

    // Idle hold of source 5
    bif.src_data[5*WIDTH +: WIDTH] = 32'hA5A5_A5A5;
    bif.src_en = N'(1) << 5;
    step();
    for (int k = 0; k < 3; k++) begin
      bif.src_en = '0;
      bif.src_data[5*WIDTH +: WIDTH] = $urandom;
      step();
      chk("idle_bus",   64'(bif.bus_out),   64'hA5A5_A5A5);
      chk("idle_sel",   64'(bif.sel_q),     64'h5);
      chk("idle_valid", 64'(bif.bus_valid), 64'h0);
    end

    // Conflict and saturation
    d_saved = $urandom;
    bif.src_data[2*WIDTH +: WIDTH] = d_saved;
    bif.src_en = N'(24'h00000C);
    step();
    chk("conf_sel",  64'(bif.sel_q),        64'h2);
    chk("conf_bus",  64'(bif.bus_out),      64'(d_saved));
    chk("conf_flag", 64'(bif.conflict),     64'h1);
    chk("conf_cnt",  64'(bif.conflict_cnt), 64'h1);
    repeat (300) step();
    chk("conf_sat", 64'(bif.conflict_cnt), 64'd255);

    // Clear beats a simultaneous conflict
    d_saved = $urandom;
    bif.src_data[0 +: WIDTH] = d_saved;
    bif.src_en = N'(24'h000003);
    bif.conflict_clr = 1'b1;
    step();
    bif.conflict_clr = 1'b0;
    chk("clrp_flag", 64'(bif.conflict),     64'h0);
    chk("clrp_cnt",  64'(bif.conflict_cnt), 64'h0);
    chk("clrp_bus",  64'(bif.bus_out),      64'(d_saved));
    chk("clrp_sel",  64'(bif.sel_q),        64'h0);

    // Hold freezes state and ignores conflict_clr
    bif.src_en = N'(24'h000006);
    step();
    d_saved = bif.bus_out; s_saved = bif.sel_q; c_saved = bif.conflict_cnt;
    chk("pre_hold_cnt", 64'(c_saved), 64'h1);
    bif.hold = 1'b1;
    bif.conflict_clr = 1'b1;
    bif.src_en = N'(24'h000010);
    bif.src_data[4*WIDTH +: WIDTH] = 32'h4444_0004;
    step();
    chk("hold_bus",   64'(bif.bus_out),      64'(d_saved));
    chk("hold_sel",   64'(bif.sel_q),        64'(s_saved));
    chk("hold_conf",  64'(bif.conflict),     64'h1);
    chk("hold_cnt",   64'(bif.conflict_cnt), 64'h1);
    chk("hold_valid", 64'(bif.bus_valid),    64'h0);
    bif.hold = 1'b0;
    bif.conflict_clr = 1'b0;
    step();
    chk("unhold_bus",   64'(bif.bus_out),   64'h4444_0004);
    chk("unhold_sel",   64'(bif.sel_q),     64'h4);
    chk("unhold_valid", 64'(bif.bus_valid), 64'h1);

    // Randomized traffic checked against the model
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < N; s++) bif.src_data[s*WIDTH +: WIDTH] = $urandom;
      case ($urandom_range(0, 3))
        0:       bif.src_en = '0;
        1:       bif.src_en = N'(1) << $urandom_range(0, N - 1);
        default: bif.src_en = N'($urandom);
      endcase
      bif.hold         = ($urandom_range(0, 7) == 0);
      bif.conflict_clr = ($urandom_range(0, 15) == 0);
      clear            = ($urandom_range(0, 99) == 0);
      step();
    end
    clear = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
